// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C controller.
// Holds FSM encoding, quarter-phase numbering and bus field widths.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int BYTE_W     = 8;

    localparam logic [I2C_ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 7'b0101010;

    // Quarter phases within one SCL bit-time
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_ADDR_ACK  = 4'd3,
        ST_WDATA     = 4'd4,
        ST_WDATA_ACK = 4'd5,
        ST_RDATA     = 4'd6,
        ST_MNACK     = 4'd7,
        ST_STOP      = 4'd8,
        ST_DONE      = 4'd9
    } state_t;

    function automatic logic is_byte_state(input state_t s);
        return (s == ST_ADDR) || (s == ST_WDATA) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit strobe generator: one tick every CLK_DIV cycles plus a 2-bit
// quarter-phase counter; both held at zero while disabled.
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       i_srst,
    input  logic       i_en,
    output logic       o_tick,
    output logic [1:0] o_phase
);

    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_phase;

    always_ff @(posedge clk) begin
        if (i_srst || !i_en) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick  = i_en && (r_cnt == CNT_LAST);
    assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: one-byte read or write per command, with
// open-drain SDA/SCL and a one-cycle response strobe.
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [BYTE_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [BYTE_W-1:0]     rsp_rdata,
    output logic                  rsp_nack,
    output logic                  busy,
    inout  wire                   sda,
    inout  wire                   scl
);

    state_t r_state;
    state_t w_next_state;

    logic              w_tick;
    logic [1:0]        w_phase;
    logic              w_tick_en;
    logic              w_bit_end;
    logic              w_sample;
    logic              w_accept;
    logic              w_scl_low;
    logic              w_sda_low;

    logic              r_rw;
    logic [BYTE_W-1:0] r_wdata;
    logic [BYTE_W-1:0] r_tx;
    logic [BYTE_W-1:0] r_rx;
    logic [2:0]        r_bit_cnt;
    logic              r_rsp_nack;
    logic [BYTE_W-1:0] r_rsp_rdata;
    logic              r_sda_meta;
    logic              r_sda_sync;
    logic              r_scl_low;
    logic              r_sda_low;

    assign w_tick_en = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_bit_end = w_tick && (w_phase == Q3);
    assign w_sample  = w_tick && (w_phase == Q2);
    assign w_accept  = cmd_valid && cmd_ready;

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .i_srst  (rst),
        .i_en    (w_tick_en),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (cmd_valid) w_next_state = ST_START;
            ST_START:     if (w_bit_end) w_next_state = ST_ADDR;
            ST_ADDR:      if (w_bit_end && (r_bit_cnt == 3'd0)) w_next_state = ST_ADDR_ACK;
            ST_ADDR_ACK:  if (w_bit_end) w_next_state = r_rsp_nack ? ST_STOP :
                                                        (r_rw ? ST_RDATA : ST_WDATA);
            ST_WDATA:     if (w_bit_end && (r_bit_cnt == 3'd0)) w_next_state = ST_WDATA_ACK;
            ST_WDATA_ACK: if (w_bit_end) w_next_state = ST_STOP;
            ST_RDATA:     if (w_bit_end && (r_bit_cnt == 3'd0)) w_next_state = ST_MNACK;
            ST_MNACK:     if (w_bit_end) w_next_state = ST_STOP;
            ST_STOP:      if (w_bit_end) w_next_state = ST_DONE;
            ST_DONE:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Bus levels per quarter; SCL is low in Q0 and Q3 of every ordinary bit
    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        cmd_ready = (r_state == ST_IDLE);
        busy      = w_tick_en || (cmd_valid && (r_state == ST_IDLE));
        rsp_valid = (r_state == ST_DONE);
        case (r_state)
            ST_START: begin
                w_scl_low = (w_phase == Q3);
                w_sda_low = (w_phase == Q2) || (w_phase == Q3);
            end
            ST_ADDR, ST_WDATA: begin
                w_scl_low = (w_phase == Q0) || (w_phase == Q3);
                w_sda_low = ~r_tx[BYTE_W-1];
            end
            ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_MNACK: begin
                w_scl_low = (w_phase == Q0) || (w_phase == Q3);
            end
            ST_STOP: begin
                w_scl_low = (w_phase == Q0);
                w_sda_low = (w_phase == Q0) || (w_phase == Q1);
            end
            default: begin
                w_scl_low = 1'b0;
                w_sda_low = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rw        <= 1'b0;
            r_wdata     <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_bit_cnt   <= 3'd7;
            r_rsp_nack  <= 1'b0;
            r_rsp_rdata <= '0;
            r_sda_meta  <= 1'b1;
            r_sda_sync  <= 1'b1;
            r_scl_low   <= 1'b0;
            r_sda_low   <= 1'b0;
        end else begin
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
            r_scl_low  <= w_scl_low;
            r_sda_low  <= w_sda_low;

            if (w_accept) begin
                r_rw       <= cmd_rw;
                r_wdata    <= cmd_wdata;
                r_tx       <= {cmd_addr, cmd_rw};
                r_rx       <= '0;
                r_rsp_nack <= 1'b0;
            end

            if ((w_next_state != r_state) && is_byte_state(w_next_state)) begin
                r_bit_cnt <= 3'd7;
                if (w_next_state == ST_WDATA) r_tx <= r_wdata;
            end else if (w_bit_end && is_byte_state(r_state)) begin
                r_bit_cnt <= r_bit_cnt - 3'd1;
                r_tx      <= {r_tx[BYTE_W-2:0], 1'b0};
            end

            if (w_sample) begin
                if (r_state == ST_RDATA) r_rx <= {r_rx[BYTE_W-2:0], r_sda_sync};
                if (((r_state == ST_ADDR_ACK) || (r_state == ST_WDATA_ACK)) && r_sda_sync)
                    r_rsp_nack <= 1'b1;
            end

            if ((r_state == ST_STOP) && (w_next_state == ST_DONE))
                r_rsp_rdata <= r_rw ? r_rx : '0;
        end
    end

    assign rsp_nack  = r_rsp_nack;
    assign rsp_rdata = r_rsp_rdata;

    assign sda = r_sda_low ? 1'b0 : 1'bz;
    assign scl = r_scl_low ? 1'b0 : 1'bz;

endmodule
